// File: rtl/prog_counter.sv
// prog_counter: programmable up/down event counter with runtime modulo limit,
// wrap or saturate behaviour, synchronous load, compare match, a one-cycle
// terminal-count pulse and sticky overflow/underflow flags.
//
// Optional feature macro: COUNTER_PRESCALER_EN
//   defined   - a prescaler stretches each tick to PRESCALE+1 enabled cycles
//   undefined - every enabled cycle is a tick; PRESCALE is accepted but ignored
module prog_counter #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      UP_DN,
  input  logic                      SATURATE,
  input  logic [WIDTH-1:0]          LIMIT,
  input  logic                      LOAD,
  input  logic [WIDTH-1:0]          LOAD_VALUE,
  input  logic [WIDTH-1:0]          COMPARE,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      CLR_FLAGS,
  output logic [WIDTH-1:0]          VALUE,
  output logic                      TC,
  output logic                      OVF,
  output logic                      UDF,
  output logic                      MATCH
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick;
  logic             stepTick;
  logic [WIDTH-1:0] nextValue;
  logic             terminal;
  logic             ovfSet;
  logic             udfSet;

`ifdef COUNTER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescaleCount;

  assign tick = EN && (prescaleCount == PRESCALE);

  // Prescaler: restarts on reset, load or tick, advances on other enabled cycles, holds otherwise
  always_ff @(posedge CLK) begin
    if (RST || LOAD) begin
      prescaleCount <= '0;
    end else if (tick) begin
      prescaleCount <= '0;
    end else if (EN) begin
      prescaleCount <= prescaleCount + 1'b1;
    end
  end
`else
  logic unusedPrescale;

  assign tick           = EN;
  assign unusedPrescale = ^PRESCALE;
`endif

  // A load in the same cycle pre-empts the tick entirely, including its flag side effects
  assign stepTick = tick && !LOAD;

  // Next count and terminal events; comparisons against the bounds keep the arithmetic carry-free
  always_comb begin
    nextValue = VALUE;
    terminal  = 1'b0;
    ovfSet    = 1'b0;
    udfSet    = 1'b0;
    if (stepTick) begin
      if (UP_DN) begin
        if (VALUE < LIMIT) begin
          nextValue = VALUE + ONE;
        end else begin
          terminal  = 1'b1;
          ovfSet    = 1'b1;
          nextValue = SATURATE ? LIMIT : '0;
        end
      end else begin
        if (VALUE != '0) begin
          nextValue = VALUE - ONE;
        end else begin
          terminal  = 1'b1;
          udfSet    = 1'b1;
          nextValue = SATURATE ? '0 : LIMIT;
        end
      end
    end
  end

  // Count, terminal pulse and sticky flags; a set event beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      VALUE <= '0;
      TC    <= 1'b0;
      OVF   <= 1'b0;
      UDF   <= 1'b0;
    end else begin
      if (LOAD) begin
        VALUE <= LOAD_VALUE;
        TC    <= 1'b0;
      end else begin
        VALUE <= nextValue;
        TC    <= terminal;
      end
      OVF <= ovfSet | (OVF & ~CLR_FLAGS);
      UDF <= udfSet | (UDF & ~CLR_FLAGS);
    end
  end

  assign MATCH = (VALUE == COMPARE);

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: scoreboard bench for prog_counter (WIDTH=8). Expected
// results come from a cycle model and are queued when stimulus is driven,
// then popped and compared one cycle later. Works with or without
// COUNTER_PRESCALER_EN defined.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic          UP_DN;
  logic          SATURATE;
  logic [W-1:0]  LIMIT;
  logic          LOAD;
  logic [W-1:0]  LOAD_VALUE;
  logic [W-1:0]  COMPARE;
  logic [PW-1:0] PRESCALE;
  logic          CLR_FLAGS;
  logic [W-1:0]  VALUE;
  logic          TC;
  logic          OVF;
  logic          UDF;
  logic          MATCH;

  typedef struct packed {
    logic [W-1:0] v;
    logic         tc;
    logic         ovf;
    logic         udf;
  } expT;

  expT expQ[$];
  expT lastExp;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  mVal;
  logic [PW-1:0] mPre;
  logic          mTc;
  logic          mOvf;
  logic          mUdf;

  prog_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .UP_DN(UP_DN), .SATURATE(SATURATE),
    .LIMIT(LIMIT), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE), .COMPARE(COMPARE),
    .PRESCALE(PRESCALE), .CLR_FLAGS(CLR_FLAGS), .VALUE(VALUE), .TC(TC),
    .OVF(OVF), .UDF(UDF), .MATCH(MATCH)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour for one clock edge, using the currently driven inputs
  task automatic modelStep();
    logic isTick;
    logic setO;
    logic setU;
    if (RST) begin
      mVal = '0; mPre = '0; mTc = 1'b0; mOvf = 1'b0; mUdf = 1'b0;
      return;
    end
    setO = 1'b0;
    setU = 1'b0;
    mTc  = 1'b0;
    if (LOAD) begin
      mVal = LOAD_VALUE;
      mPre = '0;
    end else begin
`ifdef COUNTER_PRESCALER_EN
      isTick = EN && (mPre == PRESCALE);
      if (isTick) mPre = '0;
      else if (EN) mPre = mPre + 8'd1;
`else
      isTick = EN;
`endif
      if (isTick) begin
        if (UP_DN) begin
          if (mVal >= LIMIT) begin
            setO = 1'b1; mTc = 1'b1;
            mVal = SATURATE ? LIMIT : 8'd0;
          end else begin
            mVal = mVal + 8'd1;
          end
        end else begin
          if (mVal == 8'd0) begin
            setU = 1'b1; mTc = 1'b1;
            mVal = SATURATE ? 8'd0 : LIMIT;
          end else begin
            mVal = mVal - 8'd1;
          end
        end
      end
    end
    if (CLR_FLAGS) begin
      mOvf = 1'b0; mUdf = 1'b0;
    end
    if (setO) mOvf = 1'b1;
    if (setU) mUdf = 1'b1;
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then score the DUT after the edge
  task automatic applyStimulus(input logic rst, input logic en, input logic up, input logic sat,
                               input logic [W-1:0] lim, input logic ld, input logic [W-1:0] ldv,
                               input logic clr);
    expT e;
    @(negedge CLK);
    RST = rst; EN = en; UP_DN = up; SATURATE = sat; LIMIT = lim;
    LOAD = ld; LOAD_VALUE = ldv; CLR_FLAGS = clr;
    modelStep();
    e.v = mVal; e.tc = mTc; e.ovf = mOvf; e.udf = mUdf;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queue", 32'd0, 32'd1);
    end else begin
      lastExp = expQ.pop_front();
      checkOutput("VALUE", {24'd0, VALUE}, {24'd0, lastExp.v});
      checkOutput("TC", {31'd0, TC}, {31'd0, lastExp.tc});
      checkOutput("OVF", {31'd0, OVF}, {31'd0, lastExp.ovf});
      checkOutput("UDF", {31'd0, UDF}, {31'd0, lastExp.udf});
      checkOutput("MATCH", {31'd0, MATCH}, {31'd0, (lastExp.v == COMPARE)});
    end
  endtask

  logic [W-1:0] wrapSeq [8];
  logic [W-1:0] satSeq  [5];

  initial begin
    wrapSeq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    satSeq  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    mVal = '0; mPre = '0; mTc = 1'b0; mOvf = 1'b0; mUdf = 1'b0;
    RST = 1'b1; EN = 1'b0; UP_DN = 1'b1; SATURATE = 1'b0; LIMIT = 8'd5;
    LOAD = 1'b0; LOAD_VALUE = '0; COMPARE = 8'd0; PRESCALE = '0; CLR_FLAGS = 1'b0;

    // Reset state
    applyStimulus(1, 0, 1, 0, 8'd5, 0, 8'd0, 0);
    checkOutput("reset_value", {24'd0, VALUE}, 32'd0);
    checkOutput("reset_match", {31'd0, MATCH}, 32'd1);

    // Wrap up through LIMIT=5
    COMPARE = 8'd3;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 0, 8'd5, 0, 8'd0, 0);
      checkOutput("wrap_seq", {24'd0, VALUE}, {24'd0, wrapSeq[i]});
      checkOutput("wrap_tc", {31'd0, TC}, (i == 5) ? 32'd1 : 32'd0);
      checkOutput("wrap_match", {31'd0, MATCH}, (i == 2) ? 32'd1 : 32'd0);
    end
    checkOutput("wrap_ovf", {31'd0, OVF}, 32'd1);

    // Clearing the flags while idle
    applyStimulus(0, 0, 1, 0, 8'd5, 0, 8'd0, 1);
    checkOutput("clr_ovf", {31'd0, OVF}, 32'd0);

    // Saturating down count from 2
    applyStimulus(0, 0, 0, 1, 8'd5, 1, 8'd2, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 1, 8'd5, 0, 8'd0, 0);
      checkOutput("sat_seq", {24'd0, VALUE}, {24'd0, satSeq[i]});
      checkOutput("sat_tc", {31'd0, TC}, (i >= 2) ? 32'd1 : 32'd0);
    end
    checkOutput("sat_udf", {31'd0, UDF}, 32'd1);

    // Prescaled counting from 0
    applyStimulus(1, 0, 1, 0, 8'd255, 0, 8'd0, 0);
    PRESCALE = 8'd3;
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 8'd255, 0, 8'd0, 0);
`ifdef COUNTER_PRESCALER_EN
    checkOutput("prescale_value", {24'd0, VALUE}, 32'd3);
`else
    checkOutput("prescale_value", {24'd0, VALUE}, 32'd12);
`endif
    PRESCALE = 8'd0;

    // Load beats a would-be terminal tick
    applyStimulus(1, 0, 1, 0, 8'd5, 0, 8'd0, 0);
    applyStimulus(0, 0, 1, 0, 8'd5, 1, 8'd5, 0);
    applyStimulus(0, 1, 1, 0, 8'd5, 1, 8'h10, 0);
    checkOutput("prio_value", {24'd0, VALUE}, 32'h10);
    checkOutput("prio_tc", {31'd0, TC}, 32'd0);
    checkOutput("prio_ovf", {31'd0, OVF}, 32'd0);

    // Overflow set wins over a simultaneous clear; out-of-range value overflows
    applyStimulus(0, 1, 1, 0, 8'd5, 0, 8'd0, 1);
    checkOutput("setwins_ovf", {31'd0, OVF}, 32'd1);
    checkOutput("setwins_value", {24'd0, VALUE}, 32'd0);

    // Mid-run reset with flags set
    applyStimulus(0, 0, 1, 0, 8'd20, 1, 8'd0, 0);
    applyStimulus(0, 1, 0, 0, 8'd20, 0, 8'd0, 0);
    checkOutput("down_wrap_value", {24'd0, VALUE}, 32'd20);
    applyStimulus(0, 0, 1, 0, 8'd20, 1, 8'd0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 8'd20, 0, 8'd0, 0);
    checkOutput("midrun_value", {24'd0, VALUE}, 32'd7);
    applyStimulus(1, 1, 1, 0, 8'd20, 0, 8'd0, 0);
    checkOutput("midrun_rst_value", {24'd0, VALUE}, 32'd0);
    checkOutput("midrun_rst_udf", {31'd0, UDF}, 32'd0);
    checkOutput("midrun_rst_ovf", {31'd0, OVF}, 32'd0);
    applyStimulus(0, 1, 1, 0, 8'd20, 0, 8'd0, 0);
    checkOutput("midrun_resume", {24'd0, VALUE}, 32'd1);

    // Out-of-range load then up tick, and then a down tick from above LIMIT
    applyStimulus(0, 0, 1, 0, 8'd5, 1, 8'd9, 0);
    applyStimulus(0, 1, 1, 0, 8'd5, 0, 8'd0, 0);
    checkOutput("oor_value", {24'd0, VALUE}, 32'd0);
    checkOutput("oor_tc", {31'd0, TC}, 32'd1);
    checkOutput("oor_ovf", {31'd0, OVF}, 32'd1);
    applyStimulus(0, 0, 1, 0, 8'd5, 1, 8'd9, 0);
    applyStimulus(0, 1, 0, 0, 8'd5, 0, 8'd0, 0);
    checkOutput("oor_down", {24'd0, VALUE}, 32'd8);

    // LIMIT=0: every up tick is terminal
    applyStimulus(0, 0, 1, 0, 8'd0, 1, 8'd0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 8'd0, 0, 8'd0, 0);
      checkOutput("lim0_tc", {31'd0, TC}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Programmable up/down counter, successor to the free-running counter. Adds a runtime modulo limit, wrap or saturate mode, synchronous load, compare match, a terminal-count pulse and sticky overflow/underflow flags. Used as the general event/timebase counter in timer, watchdog and performance-monitor blocks.

## Interface
- WIDTH, 32: counter width in bits (≥2).
- PRESCALE_WIDTH, 8: prescaler width in bits; used only with COUNTER_PRESCALER_EN.

- CLK  in  1  clock; everything is rising-edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  count enable.
- UP_DN  in  1  1 = count up, 0 = count down; sampled on each tick.
- SATURATE  in  1  1 = saturate at bounds, 0 = wrap.
- LIMIT  in  WIDTH  terminal value; count range is 0..LIMIT inclusive.
- LOAD  in  1  synchronous load strobe.
- LOAD_VALUE  in  WIDTH  value loaded when LOAD=1.
- COMPARE  in  WIDTH  compare value for MATCH.
- PRESCALE  in  PRESCALE_WIDTH  number of extra enabled cycles per tick.
- CLR_FLAGS  in  1  clears OVF and UDF.
- VALUE  out  WIDTH  current count, registered.
- TC  out  1  one-cycle terminal-count pulse, registered.
- OVF  out  1  sticky overflow flag.
- UDF  out  1  sticky underflow flag.
- MATCH  out  1  combinational: VALUE == COMPARE.

## Operation
- Reset values: VALUE=0, TC=0, OVF=0, UDF=0, prescaler=0. MATCH follows (0 == COMPARE).
- Tick: a cycle with EN=1 in which the prescaler equals PRESCALE. On a tick the prescaler returns to 0; on any other EN=1 cycle it increments. EN=0 holds the prescaler.
- Priority per cycle is RST > LOAD > tick.
- LOAD:
  - VALUE ← LOAD_VALUE, prescaler ← 0, TC=0.
  - No flag change, regardless of EN.
  - LOAD_VALUE > LIMIT is accepted as-is.
- Up tick:
  - If VALUE < LIMIT: VALUE+1.
  - If VALUE ≥ LIMIT: set OVF and pulse TC. Then VALUE ← 0 if SATURATE=0, or VALUE ← LIMIT if SATURATE=1.
- Down tick:
  - If VALUE > 0: VALUE−1.
  - If VALUE = 0: set UDF and pulse TC. Then VALUE ← LIMIT if SATURATE=0, or VALUE stays 0 if SATURATE=1.
  - If VALUE > LIMIT on a down tick, VALUE−1 is applied normally.
- Arithmetic is WIDTH bits. The comparisons above prevent any implicit carry or borrow. LIMIT=0 is legal: every tick is terminal.
- In saturate mode TC and the flag fire on every tick taken at the bound, not only the first.
- CLR_FLAGS clears OVF and UDF next cycle. If a set event and CLR_FLAGS occur in the same cycle, set wins.
- LIMIT, SATURATE, UP_DN and COMPARE may change at any time and take effect on the next evaluation. There is no internal shadowing.

## Timing
- VALUE, TC, OVF and UDF update on the edge ending the tick, load or reset cycle: one-cycle latency.
- TC is high for exactly one cycle, coincident with the first cycle VALUE shows the wrapped or saturated value.
- MATCH has zero latency relative to VALUE and COMPARE.
- Back-to-back ticks (PRESCALE=0, EN held high) give one count per cycle, and a TC on each terminal tick.
- Reset mid-count: the next cycle shows all reset values. Pending prescaler progress is discarded.

## Configuration
- COUNTER_PRESCALER_EN defined:
  - The prescaler register and PRESCALE port are present.
  - A tick occurs every PRESCALE+1 enabled cycles.
- COUNTER_PRESCALER_EN undefined:
  - No prescaler logic. PRESCALE is still present but ignored, so port lists match.
  - Every EN=1 cycle is a tick.
  - PRESCALE_WIDTH is unused.

## Test plan
- Wrap up: WIDTH=8, LIMIT=5, SATURATE=0, UP_DN=1, PRESCALE=0, EN=1 for 8 cycles → VALUE 1,2,3,4,5,0,1,2; TC high only when VALUE first shows 0; OVF=1 after the wrap.
- Saturate down: LOAD_VALUE=2, LOAD, then UP_DN=0, SATURATE=1, EN=1 for 5 cycles → VALUE 1,0,0,0,0; TC high on the last three cycles; UDF=1.
- Prescaler (macro defined): PRESCALE=3, EN=1 for 12 cycles from 0 → VALUE reaches 3, incrementing once every 4 cycles. Macro undefined: same stimulus → VALUE=12 (LIMIT=255).
- Priority: LOAD=1 with LOAD_VALUE=0x10, EN=1 on a would-be terminal tick → VALUE=0x10, TC=0, OVF unchanged. CLR_FLAGS asserted in the same cycle as an overflow → OVF=1.
- Mid-run reset: count to 7, assert RST for 1 cycle with EN=1 → VALUE=0, OVF=UDF=TC=0 next cycle; counting resumes at 1 after RST drops.
- Compare and out-of-range load: COMPARE=3 → MATCH high exactly while VALUE=3. LOAD_VALUE=9 with LIMIT=5, up tick → VALUE=0, TC=1, OVF=1.
